// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, constants and FSM state type for the fetch unit
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;
  localparam int PC_STEP = 2;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FULL,
    FAULT
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-two instruction buffer with synchronous flush
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Pop on empty is ignored; a full buffer only accepts a push alongside a pop.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetch into a small buffer with redirect
// Optional bound checking of fetch addresses is enabled by FETCH_BOUND_CHECK_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BUF_DEPTH = 2,
  parameter int          MEM_BYTES = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               fault
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] ONE_SHORT = CNT_W'(BUF_DEPTH - 1);

  fetch_state_e state, state_n;
  logic [PC_W-1:0]         pc_n;
  logic [CNT_W-1:0]        count;
  logic [PC_W+INSTR_W-1:0] head;
  logic                    push, pop, flush, out_of_range;

`ifdef FETCH_BOUND_CHECK_EN
  assign out_of_range = {16'd0, pc} >= 32'(MEM_BYTES);
`else
  assign out_of_range = 1'b0;
`endif

  // A head offered during a redirect is discarded by the flush, never consumed.
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign out_pc    = out_valid ? head[PC_W+INSTR_W-1:INSTR_W] : '0;
  assign out_instr = out_valid ? head[INSTR_W-1:0] : NOP_INSTR;
  assign fault     = (state == FAULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_n    = redirect_pc & ~PC_W'(1);
      state_n = FETCH;
    end else begin
      case (state)
        IDLE:  state_n = FETCH;
        FETCH: begin
          if ((count != DEPTH_C) || pop) begin
            if (out_of_range) begin
              state_n = FAULT;
            end else begin
              push = 1'b1;
              pc_n = pc + PC_W'(PC_STEP);
              if (!pop && (count == ONE_SHORT)) state_n = FULL;
            end
          end else begin
            state_n = FULL;
          end
        end
        FULL:  if (pop) state_n = FETCH;
        FAULT: state_n = FAULT;
        default: state_n = IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(BUF_DEPTH),
    .WIDTH(PC_W + INSTR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .push_data({pc, instruction}),
    .count    (count),
    .head     (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - queue-model and directed checks for fetch_unit
module tb_fetch_unit;

  localparam int DEPTH = 2;
  localparam int MEM   = 32;
`ifdef FETCH_BOUND_CHECK_EN
  localparam bit BOUND = 1'b1;
`else
  localparam bit BOUND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc, instruction, redirect_pc, out_instr, out_pc;
  logic        redirect_valid, out_valid, out_ready, fault;

  logic [15:0] mem [16];
  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [15:0] p; logic [15:0] i;} ent_t;
  ent_t        mq[$];
  logic [15:0] m_pc = 16'h0000;
  int          m_mode = 0;   // 0 waiting, 1 fetching, 2 stalled on full, 3 faulted

  fetch_unit #(.RESET_PC(16'h0000), .BUF_DEPTH(DEPTH), .MEM_BYTES(MEM)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a < 16'(MEM)) ? mem[a[4:1]] : 16'h0000;
  endfunction

  assign instruction = mem_word(pc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: an ordered list of fetched words plus the next fetch address.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_pc = 16'h0000;
      m_mode = 0;
    end else if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc & 16'hFFFE;
      m_mode = 1;
    end else begin
      bit popped;
      popped = (mq.size() > 0) && out_ready;
      if (popped) void'(mq.pop_front());
      case (m_mode)
        0: m_mode = 1;
        1: if (mq.size() < DEPTH) begin
             if (BOUND && (m_pc >= 16'(MEM))) m_mode = 3;
             else begin
               mq.push_back({m_pc, mem_word(m_pc)});
               m_pc = m_pc + 16'd2;
               if (mq.size() == DEPTH) m_mode = 2;
             end
           end else m_mode = 2;
        2: if (popped) m_mode = 1;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("cmp_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
    chk("cmp_out_pc", {16'd0, out_pc}, {16'd0, (mq.size() != 0) ? mq[0].p : 16'h0000});
    chk("cmp_out_instr", {16'd0, out_instr}, {16'd0, (mq.size() != 0) ? mq[0].i : 16'h0000});
    chk("cmp_pc", {16'd0, pc}, {16'd0, m_pc});
    chk("cmp_fault", {31'd0, fault}, {31'd0, m_mode == 3});
  end

  initial begin
    mem[0] = 16'hE109;
    mem[1] = 16'hAD07;
    for (int i = 2; i < 16; i++) mem[i] = 16'h1000 + 16'(i) * 16'h0111;
    out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    step(); step();
    chk("rst_pc", {16'd0, pc}, 32'h0);
    chk("rst_valid", {31'd0, out_valid}, 32'h0);
    chk("rst_fault", {31'd0, fault}, 32'h0);
    chk("rst_out_pc", {16'd0, out_pc}, 32'h0);
    chk("rst_out_instr", {16'd0, out_instr}, 32'h0);
    reset = 1'b0;
    step();
    chk("idle_valid", {31'd0, out_valid}, 32'h0);
    chk("idle_pc", {16'd0, pc}, 32'h0);
    step();
    chk("first_out_pc", {16'd0, out_pc}, 32'h0000);
    chk("first_instr", {16'd0, out_instr}, 32'hE109);
    chk("first_pc", {16'd0, pc}, 32'h0002);
    step();
    chk("second_out_pc", {16'd0, out_pc}, 32'h0002);
    chk("second_instr", {16'd0, out_instr}, 32'hAD07);
    chk("second_pc", {16'd0, pc}, 32'h0004);

    reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'h0);
    chk("async_rst_pc", {16'd0, pc}, 32'h0);
    out_ready = 1'b0;
    step();
    reset = 1'b0;
    repeat (6) step();
    chk("stall_valid", {31'd0, out_valid}, 32'h1);
    chk("stall_out_pc", {16'd0, out_pc}, 32'h0000);
    chk("stall_pc", {16'd0, pc}, 32'h0004);
    out_ready = 1'b1;
    step();
    chk("drain_out_pc", {16'd0, out_pc}, 32'h0002);
    chk("drain_pc", {16'd0, pc}, 32'h0004);
    step();
    chk("resume_out_pc", {16'd0, out_pc}, 32'h0004);
    chk("resume_instr", {16'd0, out_instr}, 32'h1222);
    chk("resume_pc", {16'd0, pc}, 32'h0006);

    out_ready = 1'b0;
    step();
    chk("refill_pc", {16'd0, pc}, 32'h0008);
    redirect_valid = 1'b1; redirect_pc = 16'h000B;
    step();
    redirect_valid = 1'b0;
    chk("redir_valid", {31'd0, out_valid}, 32'h0);
    chk("redir_pc", {16'd0, pc}, 32'h000A);
    step();
    chk("redir_out_pc", {16'd0, out_pc}, 32'h000A);
    chk("redir_instr", {16'd0, out_instr}, 32'h1555);

    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect_valid = 1'b0;
    chk("pop_redir_valid", {31'd0, out_valid}, 32'h0);
    chk("pop_redir_pc", {16'd0, pc}, 32'h0010);
    step();
    chk("pop_redir_out_pc", {16'd0, out_pc}, 32'h0010);
    chk("pop_redir_instr", {16'd0, out_instr}, 32'h1888);

    redirect_valid = 1'b1; redirect_pc = 16'h0018;
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("tail_out_pc", {16'd0, out_pc}, 32'h0018 + 32'(2 * k));
    end
    chk("tail_instr", {16'd0, out_instr}, 32'h1FFF);
    step();
`ifdef FETCH_BOUND_CHECK_EN
    chk("bound_fault", {31'd0, fault}, 32'h1);
    chk("bound_valid", {31'd0, out_valid}, 32'h0);
    chk("bound_pc", {16'd0, pc}, 32'h0020);
    step();
    chk("bound_hold", {31'd0, fault}, 32'h1);
`else
    chk("oob_out_pc", {16'd0, out_pc}, 32'h0020);
    chk("oob_instr", {16'd0, out_instr}, 32'h0000);
    chk("oob_fault", {31'd0, fault}, 32'h0);
`endif
    redirect_valid = 1'b1; redirect_pc = 16'h0000;
    step();
    redirect_valid = 1'b0;
    chk("clear_fault", {31'd0, fault}, 32'h0);
    chk("clear_pc", {16'd0, pc}, 32'h0000);
    step();
    chk("restart_instr", {16'd0, out_instr}, 32'hE109);

    for (int n = 0; n < 400; n++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = 16'($urandom_range(0, 47));
      step();
    end
    redirect_valid = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, byte address of the first fetch after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, number of instruction-buffer entries (power of two, 2..8).
REQ-003 SHALL have parameter MEM_BYTES, default 32, byte size of the instruction memory address space.
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port pc  output  16  byte address to the instruction memory, equal to the internal fetch PC register.
REQ-007 SHALL have port instruction  input  16  memory read data for pc, combinational in the same cycle.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-009 SHALL have port redirect_pc  input  16  target byte address.
REQ-010 SHALL have port out_valid  output  1  buffer head holds a valid instruction.
REQ-011 SHALL have port out_ready  input  1  decoder accepts the head this cycle.
REQ-012 SHALL have port out_instr  output  16  head instruction.
REQ-013 SHALL have port out_pc  output  16  byte address of the head instruction.
REQ-014 SHALL have port fault  output  1  out-of-range fetch detected (REQ-031).

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, FULL, FAULT.
- IDLE: entered on reset; exits to FETCH on the first clock edge after reset release.
REQ-016 In FETCH, each edge SHALL push {pc, instruction} into the buffer and advance pc by 2, modulo 2^16.
REQ-017 A push SHALL occur only when the entry count < BUF_DEPTH, or when a pop happens in the same cycle.
REQ-018 When the buffer would be full with no pop, the FSM SHALL go FETCH->FULL; pc SHALL hold.
- In FULL, no push occurs; any pop returns the FSM to FETCH on that edge.
REQ-019 A pop SHALL occur on an edge where out_valid && out_ready.
- out_valid SHALL be high exactly when the count is non-zero.
- out_instr/out_pc SHALL present the oldest entry.
REQ-020 Fetch-to-output latency SHALL be one cycle: an entry pushed on edge N is visible on out_* after edge N when the buffer was empty.
REQ-021 redirect_valid SHALL have priority over push and pop in every state, on that edge:
- flush all entries
- load pc with {redirect_pc[15:1],1'b0} (bit 0 forced to 0)
- go to FETCH
- clear fault
REQ-022 After a redirect, out_valid SHALL be low for exactly one cycle; the target instruction appears after the next edge.
REQ-023 A head entry presented with out_ready high in the same cycle as redirect_valid SHALL be discarded, not counted as consumed.
REQ-024 Buffer count SHALL never exceed BUF_DEPTH or underflow. Pop on empty SHALL be ignored.
REQ-025 With BUF_DEPTH entries held and out_ready held high, throughput SHALL be one instruction per cycle.

Reset
REQ-026 Reset SHALL asynchronously force:
- state IDLE
- pc=RESET_PC
- buffer empty
- out_valid=0, out_instr=0, out_pc=0, fault=0
REQ-027 Reset asserted mid-operation SHALL discard all buffered entries; no partial push survives.
REQ-028 The first push after reset release SHALL be on the second edge, with out_pc=RESET_PC.

Configuration
REQ-029 Macro FETCH_BOUND_CHECK_EN SHALL select bound checking.
REQ-030 Without FETCH_BOUND_CHECK_EN, fetches at pc >= MEM_BYTES SHALL proceed normally; the memory returns 16'h0000 and these entries pass through as NOPs. fault SHALL stay 0.
REQ-031 With FETCH_BOUND_CHECK_EN, when the FSM would push with pc >= MEM_BYTES:
- do not push
- go to FAULT and set fault=1
- pc holds
- already buffered entries still drain
- only reset or redirect leaves FAULT

Structure
REQ-032 Package fetch_pkg SHALL hold:
- the FSM state enum
- INSTR_W=16, PC_W=16, PC_STEP=2, NOP_INSTR=16'h0000
REQ-033 The buffer SHALL be a sub-module fetch_fifo with these features:
- parameterised depth and width
- push, pop, flush, count, head
- synchronous flush, asynchronous reset

Verification
REQ-034 Reset release, out_ready=1, memory word0=16'hE109, word1=16'hAD07 -> out_pc 0x0000 then 0x0002 on consecutive cycles, instructions matching; pc increments by 2 each cycle.
REQ-035 out_ready=0 for 6 cycles, BUF_DEPTH=2:
- two entries (pc 0, 2) buffered, state FULL, pc=0x0004 held
- out_ready=1 -> drain in order, fetch resumes 0x0004
REQ-036 Redirect to 0x000B while 2 entries buffered:
- next cycle out_valid=0, pc=0x000A
- following cycle out_pc=0x000A
REQ-037 Redirect asserted on the same edge as a head pop -> popped entry not re-presented and not counted consumed; redirect target fetched.
REQ-038 FETCH_BOUND_CHECK_EN defined, MEM_BYTES=32, sequential run from 0:
- entries 0x0000..0x001E delivered, then fault=1, out_valid=0 after drain
- redirect to 0 clears fault

Without the macro, the same run delivers out_pc 0x0020 with out_instr 0x0000.
